// File: rtl/des_round_engine_if.sv
// Bus bundle for des_round_engine: block handshake plus the key-schedule and S-box bank links.
interface des_round_engine_if;
  localparam int unsigned BLOCK_W  = 64;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned SBOXO_W  = 32;
  localparam int unsigned IDX_W    = 4;

  logic                start;
  logic                decrypt;
  logic [BLOCK_W-1:0]  block_in;
  logic [SUBKEY_W-1:0] subkey;
  logic [IDX_W-1:0]    round_idx;
  logic [SUBKEY_W-1:0] sbox_in;
  logic [SBOXO_W-1:0]  sbox_out;
  logic                busy;
  logic                done;
  logic [BLOCK_W-1:0]  block_out;

  // Engine side
  modport slave (
    input  start, decrypt, block_in, subkey, sbox_out,
    output round_idx, sbox_in, busy, done, block_out
  );

  // Surrounding logic side (controller, key schedule, S-box bank)
  modport master (
    output start, decrypt, block_in, subkey, sbox_out,
    input  round_idx, sbox_in, busy, done, block_out
  );
endinterface

// File: rtl/des_round_engine.sv
// Iterative DES Feistel round engine: one round per clock, 16 rounds per block.
// Drives the external S-box bank with E(R)^subkey and folds P(sbox_out) back into L.
// Optional feature macro: DES_IP_FP_EN (apply IP on load and FP on block_out).
module des_round_engine (
  input  logic               clk,
  input  logic               rst,
  des_round_engine_if.slave  bus
);
  localparam int unsigned HALF_W   = 32;
  localparam int unsigned BLOCK_W  = 64;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned RND_W    = 4;

  // Expansion E: output bit i (DES numbering, MSB first) takes R bit E_TBL[i]
  localparam int unsigned E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  // Permutation P applied to the concatenated S-box outputs
  localparam int unsigned P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

`ifdef DES_IP_FP_EN
  localparam int unsigned IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int unsigned FP_TBL [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
  };

  function automatic logic [BLOCK_W-1:0] ip_perm(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] fp_perm(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
    return y;
  endfunction
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUND  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                load;
  logic                advance;
  logic                finish;

  logic [HALF_W-1:0]   l_q;
  logic [HALF_W-1:0]   r_q;
  logic [RND_W-1:0]    rnd_q;
  logic                dec_q;
  logic                busy_q;
  logic                done_q;
  logic [BLOCK_W-1:0]  block_out_q;

  logic [SUBKEY_W-1:0] e_r;
  logic [HALF_W-1:0]   f_out;
  logic [BLOCK_W-1:0]  load_blk;
  logic [BLOCK_W-1:0]  out_blk;

  // Block-boundary permutations: real IP/FP or raw pass-through
`ifdef DES_IP_FP_EN
  assign load_blk = ip_perm(bus.block_in);
  assign out_blk  = fp_perm({r_q, l_q});
`else
  assign load_blk = bus.block_in;
  assign out_blk  = {r_q, l_q};
`endif

  // Expansion of the current right half
  always_comb begin
    e_r = '0;
    for (int i = 0; i < 48; i++) e_r[6'(47 - i)] = r_q[5'(32 - E_TBL[i])];
  end

  // P permutation of the returned S-box word
  always_comb begin
    f_out = '0;
    for (int i = 0; i < 32; i++) f_out[5'(31 - i)] = bus.sbox_out[5'(32 - P_TBL[i])];
  end

  // For a 4-bit counter 15-rnd equals ~rnd
  assign bus.round_idx = dec_q ? ~rnd_q : rnd_q;
  assign bus.sbox_in   = e_r ^ bus.subkey;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.block_out = block_out_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        advance = 1'b1;
        if (rnd_q == 4'd15) state_nxt = FINISH;
      end
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Feistel halves, round counter, status and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      l_q         <= '0;
      r_q         <= '0;
      rnd_q       <= '0;
      dec_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      block_out_q <= '0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= finish;
      if (load) begin
        l_q   <= load_blk[63:32];
        r_q   <= load_blk[31:0];
        dec_q <= bus.decrypt;
        rnd_q <= '0;
      end else if (advance) begin
        l_q   <= r_q;
        r_q   <= l_q ^ f_out;
        rnd_q <= rnd_q + 4'd1;
      end
      if (finish) block_out_q <= out_blk;
    end
  end
endmodule

// File: tb/tb_des_round_engine.sv
// Self-checking bench for des_round_engine: key schedule and S-box bank models,
// reference DES model, scoreboard of expected results checked on each done pulse.
module tb_des_round_engine;
  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SBOX_T [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  typedef struct {
    logic [63:0] value;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] ks [16];
  exp_t        sb_q [$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          last_done_cyc = 0;
  int          prev_done_cyc = 0;
  logic        done_prev = 1'b0;

  des_round_engine_if bus ();

  des_round_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ip_p(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_p(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_p(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_p(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] e_p(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] p_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  // S-box bank: S1 on the top six bits, row = outer bits, column = inner four
  function automatic logic [31:0] sbox_bank(input logic [47:0] x);
    logic [31:0] s;
    logic [5:0]  six;
    int          row;
    int          col;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      six = x[6'(47 - 6 * i) -: 6];
      row = int'({six[5], six[0]});
      col = int'(six[4:1]);
      s   = {s[27:0], 4'(SBOX_T[9'(i * 64 + row * 16 + col)])};
    end
    return s;
  endfunction

  // Reference DES with IP/FP, using the current key schedule
  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic dec);
    logic [63:0] b;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] t;
    b = ip_p(blk);
    l = b[63:32];
    r = b[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ p_p(sbox_bank(e_p(r) ^ ks[4'(dec ? 15 - i : i)]));
      l = t;
    end
    return fp_p({r, l});
  endfunction

  // Value driven onto block_in / view of block_out, depending on whether the DUT owns IP/FP
  function automatic logic [63:0] fwd(input logic [63:0] pt);
`ifdef DES_IP_FP_EN
    return pt;
`else
    return ip_p(pt);
`endif
  endfunction

  function automatic logic [63:0] view(input logic [63:0] bo);
`ifdef DES_IP_FP_EN
    return bo;
`else
    return fp_p(bo);
`endif
  endfunction

  task automatic set_key(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    cd = pc1_p(key);
    c  = cd[55:28];
    d  = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFT_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[r] = pc2_p({c, d});
    end
  endtask

  // Key schedule and S-box bank responders
  always_comb bus.subkey   = ks[bus.round_idx];
  always_comb bus.sbox_out = sbox_bank(bus.sbox_in);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Scoreboard: each done pulse must match the oldest accepted block
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.done) begin
      check("done_one_cycle", 64'(done_prev), 64'd0);
      check("done_pending", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("block_out", view(bus.block_out), e.value);
        // done is seen in the cycle after edge T+17, i.e. 17 cycle indices after the start edge
        check("latency", 64'(cyc - e.cyc), 64'd17);
      end
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
    done_prev <= bus.done;
  end

  // Drive start at the current negedge; record acceptance after the next rising edge
  task automatic issue(input logic [63:0] pt, input logic dec, input logic [63:0] want);
    exp_t e;
    bus.start    = 1'b1;
    bus.decrypt  = dec;
    bus.block_in = fwd(pt);
    @(posedge clk);
    #1;
    e.value = want;
    e.cyc   = cyc;
    sb_q.push_back(e);
    bus.start = 1'b0;
  endtask

  task automatic start_block(input logic [63:0] pt, input logic dec, input logic [63:0] want);
    @(negedge clk);
    issue(pt, dec, want);
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget && sb_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] pt;
    logic [63:0] pt2;
    logic [63:0] want;
    logic [63:0] want2;
    logic        dec;
    int          n;

    // Reset with start held high: nothing may load
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.decrypt  = 1'b0;
    bus.block_in = 64'hA5A5_5A5A_0F0F_F0F0;
    set_key(KAT_KEY);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_block_out", bus.block_out, 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(bus.busy), 64'd0);

    // Known-answer encrypt, subkey order 0..15
    start_block(KAT_PT, 1'b0, KAT_CT);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("enc_round_idx", 64'(bus.round_idx), 64'(i));
    end
    check("enc_busy", 64'(bus.busy), 64'd1);
    wait_drain(40);

    // Known-answer decrypt, subkey order 15..0
    start_block(KAT_CT, 1'b1, KAT_PT);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("dec_round_idx", 64'(bus.round_idx), 64'(15 - i));
    end
    wait_drain(40);

    // Starts during rounds 3 and 10 are ignored
    pt   = {$urandom, $urandom};
    want = des_model(pt, 1'b0);
    start_block(pt, 1'b0, want);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.decrypt  = 1'b1;
    bus.block_in = ~pt;
    check("busy_r3", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    check("busy_r10", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.decrypt = 1'b0;
    wait_drain(40);

    // Reset at round 8 aborts the block with no done
    pt   = {$urandom, $urandom};
    want = des_model(pt, 1'b0);
    start_block(pt, 1'b0, want);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_block_out", bus.block_out, 64'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_idle_busy", 64'(bus.busy), 64'd0);
    check("abort_keep_out", bus.block_out, 64'd0);

    // Back-to-back: second start in the done cycle
    set_key({$urandom, $urandom});
    pt    = {$urandom, $urandom};
    pt2   = {$urandom, $urandom};
    want  = des_model(pt, 1'b0);
    want2 = des_model(pt2, 1'b1);
    start_block(pt, 1'b0, want);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", 64'(bus.done), 64'd1);
    issue(pt2, 1'b1, want2);
    wait_drain(40);
    check("b2b_spacing", 64'(last_done_cyc - prev_done_cyc), 64'd18);

    // Boundary blocks and random keys/blocks in both directions
    set_key(KAT_KEY);
    start_block(64'h0, 1'b0, des_model(64'h0, 1'b0));
    wait_drain(40);
    start_block(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, des_model(64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
    wait_drain(40);
    for (int k = 0; k < 6; k++) begin
      set_key({$urandom, $urandom});
      pt  = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      start_block(pt, dec, des_model(pt, dec));
      wait_drain(40);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
